// File: rtl/mflushpwr_pkg.sv
// mflushpwr_pkg: shared state encoding and default parameters for the mflushpwr event generator
package mflushpwr_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, REPORT} state_t;
  localparam int COREID_W_DEF = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;
endpackage

// File: rtl/mflushpwr_timeout_ctr.sv
// mflushpwr_timeout_ctr: saturating flush wait counter; expired flags the last allowed wait cycle
import mflushpwr_pkg::*;
module mflushpwr_timeout_ctr #(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [15:0] count;
  // count flush cycles from the acceptance point, holding at LIMIT
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable && count != 16'(LIMIT)) count <= count + 16'd1;
  assign expired = enable && count == 16'(LIMIT - 1);
endmodule

// File: rtl/mflushpwr_event_gen.sv
// mflushpwr_event_gen: CSR-triggered L2 flush with one-shot difftest event; MFLUSHPWR_TIMEOUT_EN enables the flush timeout
import mflushpwr_pkg::*;
module mflushpwr_event_gen #(
  parameter int COREID_W = COREID_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [COREID_W-1:0] io_coreid,
  input  logic                io_csrWrite_valid,
  output logic                io_csrWrite_ready,
  output logic                io_l2Flush_req,
  input  logic                io_l2Flush_ack,
  output logic                io_busy,
  output logic                io_evt_enable,
  output logic                io_evt_valid,
  output logic                io_evt_l2FlushDone,
  output logic [COREID_W-1:0] io_evt_coreid,
  output logic                io_timeout
);
  state_t state;
  logic [COREID_W-1:0] coreid_q;
  logic done;
  logic expired;
`ifdef MFLUSHPWR_TIMEOUT_EN
  logic accept;
  assign accept = state == IDLE && io_csrWrite_valid;
  mflushpwr_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_ctr (
    .clock(clock),
    .reset_n(reset_n),
    .clear(accept),
    .enable(state == FLUSH),
    .expired(expired)
  );
  // sticky timeout: cleared by a new request, set only when expiry is not rescued by an ack
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) io_timeout <= 1'b0;
    else if (accept) io_timeout <= 1'b0;
    else if (state == FLUSH && expired && !io_l2Flush_ack) io_timeout <= 1'b1;
`else
  assign expired = 1'b0;
  assign io_timeout = 1'b0;
`endif
  assign io_evt_valid = io_evt_enable;
  assign io_evt_l2FlushDone = done;
  // control FSM with registered outputs; event fields only change on entry to REPORT
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state             <= IDLE;
      io_csrWrite_ready <= 1'b1;
      io_l2Flush_req    <= 1'b0;
      io_busy           <= 1'b0;
      io_evt_enable     <= 1'b0;
      done              <= 1'b0;
      coreid_q          <= '0;
      io_evt_coreid     <= '0;
    end else
      case (state)
        IDLE:
          if (io_csrWrite_valid) begin
            state             <= FLUSH;
            coreid_q          <= io_coreid;
            io_csrWrite_ready <= 1'b0;
            io_l2Flush_req    <= 1'b1;
            io_busy           <= 1'b1;
          end
        FLUSH:
          if (io_l2Flush_ack || expired) begin
            state          <= REPORT;
            done           <= io_l2Flush_ack;
            io_evt_coreid  <= coreid_q;
            io_l2Flush_req <= 1'b0;
            io_evt_enable  <= 1'b1;
          end
        REPORT: begin
          state             <= IDLE;
          io_evt_enable     <= 1'b0;
          io_busy           <= 1'b0;
          io_csrWrite_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mflushpwr_event_gen.sv
// tb_mflushpwr_event_gen: randomized scoreboard bench for mflushpwr_event_gen
module tb_mflushpwr_event_gen;
  localparam int T = 16;
`ifdef MFLUSHPWR_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  typedef struct {
    logic [7:0] id;
    bit         done;
    bit         to;
    int         flen;
  } exp_t;

  logic clock = 0, reset_n = 0;
  logic [7:0] io_coreid = '0;
  logic io_csrWrite_valid = 0, io_l2Flush_ack = 0;
  logic io_csrWrite_ready, io_l2Flush_req, io_busy, io_evt_enable, io_evt_valid;
  logic io_evt_l2FlushDone, io_timeout;
  logic [7:0] io_evt_coreid;
  int tests = 0, fails = 0, run = 0;
  exp_t q[$];
  logic [7:0] last_id = '0;
  bit last_done = 0, last_to = 0;

  mflushpwr_event_gen #(.COREID_W(8), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n), .io_coreid(io_coreid),
    .io_csrWrite_valid(io_csrWrite_valid), .io_csrWrite_ready(io_csrWrite_ready),
    .io_l2Flush_req(io_l2Flush_req), .io_l2Flush_ack(io_l2Flush_ack), .io_busy(io_busy),
    .io_evt_enable(io_evt_enable), .io_evt_valid(io_evt_valid),
    .io_evt_l2FlushDone(io_evt_l2FlushDone), .io_evt_coreid(io_evt_coreid),
    .io_timeout(io_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every event strobe and measures flush request length
  always @(negedge clock) begin
    if (!reset_n) run = 0;
    else if (io_evt_enable) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: coreid %0d with empty scoreboard at %0t", io_evt_coreid, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("evt_done", io_evt_l2FlushDone, e.done);
        chk("evt_coreid", io_evt_coreid, e.id);
        chk("evt_timeout", io_timeout, e.to);
        chk("req_len", run, e.flen);
        chk("evt_valid", io_evt_valid, 1);
        chk("evt_ready", io_csrWrite_ready, 0);
        chk("evt_busy", io_busy, 1);
      end
      run = 0;
    end else if (io_l2Flush_req) run++;
  end

  // one transaction: idle gap with stray acks, accept, ack in flush cycle k (k>T means never under timeout)
  task automatic txn(input logic [7:0] id, input int k, input int gap, input bit keep);
    exp_t e;
    int n;
    bit tmo;
    repeat (gap) begin
      io_l2Flush_ack = 1'($urandom_range(0, 1));
      io_csrWrite_valid = 1'b0;
      @(posedge clock); #1;
    end
    io_l2Flush_ack = 1'b0;
    chk("idle_ready", io_csrWrite_ready, 1);
    chk("idle_req", io_l2Flush_req, 0);
    tmo = TEN && k > T;
    n = tmo ? T : k;
    e.id = id; e.done = !tmo; e.to = tmo; e.flen = n;
    q.push_back(e);
    io_coreid = id;
    io_csrWrite_valid = 1'b1;
    @(posedge clock); #1;
    chk("flush_req", io_l2Flush_req, 1);
    chk("flush_ready", io_csrWrite_ready, 0);
    chk("flush_to_clear", io_timeout, 0);
    io_coreid = 8'($urandom);
    for (int i = 1; i <= n; i++) begin
      io_csrWrite_valid = keep ? 1'b1 : 1'($urandom_range(0, 1));
      io_l2Flush_ack = i == k;
      @(posedge clock); #1;
    end
    io_l2Flush_ack = 1'($urandom_range(0, 1));
    io_csrWrite_valid = keep ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    io_l2Flush_ack = 1'b0;
    io_csrWrite_valid = 1'b0;
    last_id = id; last_done = !tmo; last_to = tmo;
    chk("post_ready", io_csrWrite_ready, 1);
    chk("post_timeout", io_timeout, last_to);
    chk("hold_coreid", io_evt_coreid, last_id);
    chk("hold_done", io_evt_l2FlushDone, last_done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", io_csrWrite_ready, 1);
    chk("rst_req", io_l2Flush_req, 0);
    chk("rst_busy", io_busy, 0);
    chk("rst_evt", io_evt_enable, 0);
    chk("rst_evt_valid", io_evt_valid, 0);
    chk("rst_done", io_evt_l2FlushDone, 0);
    chk("rst_coreid", io_evt_coreid, 0);
    chk("rst_timeout", io_timeout, 0);
    reset_n = 1'b1;
    txn(8'h03, 4, 2, 1'b0);
    txn(8'h11, 1, 0, 1'b0);
    txn(8'h22, T - 1, 1, 1'b0);
    txn(8'h33, T, 1, 1'b0);
    txn(8'h44, T + 5, 1, 1'b0);
    txn(8'h55, 2, 3, 1'b0);
    if (!TEN) txn(8'h66, 300, 1, 1'b0);
    for (int c = 0; c < 4; c++) txn(8'(8'h70 + c), 2, 0, 1'b1);
    io_coreid = 8'hAA;
    io_csrWrite_valid = 1'b1;
    @(posedge clock); #1;
    io_csrWrite_valid = 1'b0;
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("arst_req", io_l2Flush_req, 0);
    chk("arst_ready", io_csrWrite_ready, 1);
    chk("arst_busy", io_busy, 0);
    @(posedge clock); #1;
    chk("arst_evt", io_evt_enable, 0);
    chk("arst_coreid", io_evt_coreid, 0);
    reset_n = 1'b1;
    txn(8'h5A, 3, 1, 1'b0);
    for (int c = 0; c < 40; c++) begin
      int r, k;
      r = $urandom_range(0, 9);
      k = r < 6 ? $urandom_range(1, 5) : r == 6 ? T - 1 : r == 7 ? T : r == 8 ? T + 1 : $urandom_range(T + 2, 40);
      txn(8'($urandom), k, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    repeat (5) @(posedge clock);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mflushpwr_event_gen.md
MFLUSHPWR_EVENT_GEN -- requirements
Module: mflushpwr_event_gen

Interface
REQ-001 SHALL have parameter COREID_W, default 8, hart-id width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, flush wait limit in cycles (range 2..65535).
REQ-003 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port io_coreid  in  COREID_W  hart id.
REQ-006 SHALL have port io_csrWrite_valid  in  1  custom mflushpwr CSR write request.
REQ-007 SHALL have port io_csrWrite_ready  out  1  request accepted this cycle when high together with valid.
REQ-008 SHALL have port io_l2Flush_req  out  1  level flush request to L2.
REQ-009 SHALL have port io_l2Flush_ack  in  1  one-cycle flush-complete pulse from L2.
REQ-010 SHALL have port io_busy  out  1  high in any state except IDLE.
REQ-011 SHALL have port io_evt_enable  out  1  one-cycle strobe to the difftest event sink.
REQ-012 SHALL have port io_evt_valid  out  1  event valid; equals io_evt_enable.
REQ-013 SHALL have port io_evt_l2FlushDone  out  1  1 = flush acked, 0 = timed out.
REQ-014 SHALL have port io_evt_coreid  out  COREID_W  coreid captured at acceptance.
REQ-015 SHALL have port io_timeout  out  1  sticky timeout flag.

Function
REQ-016 FSM SHALL have states IDLE, FLUSH, REPORT.
REQ-017 io_csrWrite_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: valid&ready at cycle N SHALL capture io_coreid, clear io_timeout, clear wait counter, and enter FLUSH at N+1.
REQ-019 FLUSH: io_l2Flush_req SHALL be 1; the wait counter SHALL increment each cycle, saturating at TIMEOUT_CYCLES.
REQ-020 FLUSH with io_l2Flush_ack at cycle M SHALL latch done=1 and enter REPORT at M+1.
REQ-021 FLUSH with counter reaching TIMEOUT_CYCLES-1 and no ack SHALL latch done=0, set io_timeout, and enter REPORT.
REQ-022 If ack and timeout coincide, ack SHALL win: done=1, io_timeout unchanged.
REQ-023 REPORT: io_evt_enable and io_evt_valid SHALL be 1 for exactly one cycle, with io_evt_l2FlushDone=done and io_evt_coreid=captured value; next state is IDLE.
REQ-024 io_evt_l2FlushDone and io_evt_coreid SHALL hold their values outside REPORT.
REQ-025 io_l2Flush_ack in IDLE or REPORT SHALL be ignored, with no state change.
REQ-026 io_csrWrite_valid outside IDLE SHALL be ignored; it is not queued.
REQ-027 Minimum request-to-request spacing SHALL be 3 cycles: ack in the first FLUSH cycle gives accept N, REPORT N+2, ready N+3.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, counter=0, done=0, io_timeout=0, captured coreid=0, and all outputs 0 except io_csrWrite_ready=1.
REQ-029 Reset mid-FLUSH SHALL drop io_l2Flush_req asynchronously and SHALL emit no event.

Configuration
REQ-030 Macro MFLUSHPWR_TIMEOUT_EN defined: REQ-019/021/022 timeout behaviour SHALL apply.
REQ-031 Macro undefined: there SHALL be no counter; FLUSH waits indefinitely for ack, io_timeout is tied 0, and TIMEOUT_CYCLES is unused.

Structure
REQ-032 Package mflushpwr_pkg SHALL hold the state enum typedef, the default COREID_W, and the default TIMEOUT_CYCLES.
REQ-033 The wait counter SHALL be sub-module mflushpwr_timeout_ctr (clear, enable, expired output), instantiated only under MFLUSHPWR_TIMEOUT_EN.

Verification
REQ-034 Reset deasserted, coreid=8'h03, valid at cycle 10, ack at cycle 14 -> l2Flush_req high cycles 11-14; evt_enable only at 15 with l2FlushDone=1, coreid=03; ready at 16.
REQ-035 TIMEOUT_CYCLES=16, macro on, no ack -> req high 16 cycles; evt_enable with l2FlushDone=0; io_timeout=1 until the next accept.
REQ-036 Ack on the same cycle as expiry -> l2FlushDone=1, io_timeout=0.
REQ-037 valid held high continuously, ack 2 cycles after each req -> exactly one event per 4-cycle transaction; extra valids not queued; stray ack in IDLE ignored.
REQ-038 reset_n pulsed low mid-FLUSH -> req drops immediately; no evt_enable; next request works normally.
REQ-039 Macro off, ack delayed 100000 cycles -> no timeout; single event with l2FlushDone=1.
